mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one unified single-ported memory bus between the pipeline's instruction-fetch requester (imem) and the data-access requester in the MEM stage (dmem). One transaction is outstanding at a time. dmem wins ties, and a starvation counter bounds how long fetch can be locked out. The block sits between the core's fetch/MEM stages and the memory bus interface; the core stalls on each requester until that requester's ack.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive dmem grants with imem waiting before imem is forced through; must be ≥1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  in  1  fetch read request; held with imem_addr until imem_ack
- imem_addr  in  AW  fetch address
- imem_ack  out  1  one-cycle pulse: fetch complete, imem_rdata valid
- imem_rdata  out  DW  fetched word
- dmem_req  in  1  data request; held with dmem_we, dmem_addr and dmem_wdata until dmem_ack
- dmem_we  in  1  1 = write, 0 = read
- dmem_addr  in  AW  data address
- dmem_wdata  in  DW  store data
- dmem_ack  out  1  one-cycle pulse: data access complete, dmem_rdata valid for reads
- dmem_rdata  out  DW  load data
- bus_req  out  1  bus request
- bus_we  out  1  bus write enable
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_ready  in  1  bus accepts the request this cycle (qualified by bus_req)
- bus_rvalid  in  1  bus response this cycle (read data or write completion)
- bus_rdata  in  DW  bus read data
- busy  out  1  high in any state except IDLE

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. An owner register (IMEM/DMEM) records who holds the current grant.
- IDLE: if no request is pending, stay in IDLE. Otherwise grant, capture the granted requester's we/addr/wdata into registers and go to ISSUE. An imem grant always captures we=0.
- Grant rule:
  - dmem_req alone: grant dmem.
  - imem_req alone: grant imem.
  - Both: grant imem if starve_cnt == STARVE_MAX, else grant dmem.
- ISSUE: bus_req=1 and the bus_* outputs come from the captured registers. On bus_ready, go to WAIT; otherwise hold ISSUE with all bus outputs stable.
- WAIT: on bus_rvalid, register bus_rdata into the owner's rdata register and go to RESP.
- RESP: the owner's ack = 1 for exactly one cycle, then go to IDLE. No arbitration happens in RESP, so a request still high during its own ack is never granted twice.
- starve_cnt (width $clog2(STARVE_MAX+1)), updated at each IDLE grant:
  - dmem granted while imem_req is high: increment, saturating at STARVE_MAX.
  - imem granted: clear to 0.
  - imem_req low at an IDLE grant: clear to 0.
- bus_rvalid is ignored in IDLE, ISSUE and RESP.
- rdata registers hold their last value between acks. Both acks are never high in the same cycle.

## Timing
- Reset values (asynchronous): state=IDLE, owner=IMEM, starve_cnt=0. Every output is 0: bus_req, bus_we, bus_addr, bus_wdata, imem_ack, dmem_ack, imem_rdata, dmem_rdata, busy.
- Best-case latency: request sampled in IDLE at cycle N, bus_req high at N+1, bus_ready at N+1, bus_rvalid at N+2, ack at N+3. Throughput is therefore one transaction per 4 cycles at best.
- Each bus_ready stall cycle or bus_rvalid wait cycle adds exactly one cycle to latency.
- A requester may change its request in the cycle after its ack. The IDLE cycle that follows samples the new value.
- Reset mid-transaction: the FSM returns to IDLE immediately and the in-flight bus transaction is abandoned. A stale bus_rvalid arriving afterwards is ignored, and no ack is produced for the aborted request.
- Writes also wait for bus_rvalid as the completion signal. dmem_rdata is undefined-but-held after a write ack; it is not updated.

## Structure
- Add to package types:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
  - typedef struct packed mem_req_t {we, addr[31:0], wdata[31:0]} for the captured request register
- Add to package constants: localparam OWNER_IMEM = 1'b0 and OWNER_DMEM = 1'b1.
- Single module, no sub-modules. The FSM, capture registers and starvation counter are all local.

## Test plan
- Reset then imem_req=1, imem_addr=0x0000_0010, bus_ready=1, rvalid one cycle later with bus_rdata=0x0050_0093: bus_addr=0x10 and bus_we=0; imem_ack and imem_rdata=0x0050_0093 at N+3; dmem_ack stays 0.
- Both requesters high in the same IDLE cycle with starve_cnt=0: dmem granted first (bus_addr=dmem_addr); imem granted on the next IDLE, with exactly one ack per transaction.
- Both requesters held high continuously, STARVE_MAX=4: grant order is D,D,D,D,I,D,D,D,D,I.
- dmem write, we=1, addr=0x100, wdata=0xDEAD_BEEF, bus_ready low for 3 cycles: bus_* outputs stay stable through the stall; dmem_ack 3 cycles later than best case; dmem_rdata unchanged.
- Reset asserted in WAIT, then bus_rvalid pulses after reset is released: outputs go to 0 asynchronously, no ack occurs, and state is IDLE with busy=0.
- bus_rvalid asserted spuriously while IDLE and while in ISSUE: no state change and no ack.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the unified memory-port arbiter.
// arb_state_t : arbiter FSM state (IDLE -> ISSUE -> WAIT -> RESP -> IDLE)
// mem_req_t   : request captured at grant time and replayed onto the bus
// OWNER_*     : encoding of the owner register (who holds the current grant)
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    // Captured request; widths are fixed at 32 bits, so AW and DW must be <= 32.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic OWNER_IMEM = 1'b0;
    localparam logic OWNER_DMEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory bus between instruction fetch (imem) and
// the MEM-stage data port (dmem). One transaction is in flight at a time,
// dmem wins ties, and a starvation counter forces fetch through after
// STARVE_MAX consecutive dmem grants taken while fetch was waiting.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   imem_req/addr               fetch request, held until imem_ack
//   imem_ack/rdata              one-cycle completion pulse and fetched word
//   dmem_req/we/addr/wdata      data request, held until dmem_ack
//   dmem_ack/rdata              one-cycle completion pulse and load data
//   bus_req/we/addr/wdata       request to the memory bus
//   bus_ready                   bus accepts the request this cycle
//   bus_rvalid/rdata            bus response (read data or write completion)
//   busy                        arbiter is not idle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          imem_req,
    input  logic [AW-1:0] imem_addr,
    output logic          imem_ack,
    output logic [DW-1:0] imem_rdata,
    input  logic          dmem_req,
    input  logic          dmem_we,
    input  logic [AW-1:0] dmem_addr,
    input  logic [DW-1:0] dmem_wdata,
    output logic          dmem_ack,
    output logic [DW-1:0] dmem_rdata,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy
);

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIMIT = SCW'(STARVE_MAX);

    arb_state_t     state_q, state_d;
    logic           owner_q, owner_d;
    mem_req_t       req_q, req_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    logic [DW-1:0]  imem_rdata_q, imem_rdata_d;
    logic [DW-1:0]  dmem_rdata_q, dmem_rdata_d;
    logic           grant_imem;

    // Fetch only beats a simultaneous data request once it has been passed
    // over STARVE_MAX times in a row.
    always_comb begin
        grant_imem = imem_req && (!dmem_req || (starve_cnt_q == STARVE_LIMIT));
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        req_d        = req_q;
        starve_cnt_d = starve_cnt_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (imem_req || dmem_req) begin
                    state_d = ARB_ISSUE;
                    if (grant_imem) begin
                        owner_d      = OWNER_IMEM;
                        req_d.we     = 1'b0;
                        req_d.addr   = 32'(imem_addr);
                        req_d.wdata  = '0;
                        starve_cnt_d = '0;
                    end else begin
                        owner_d     = OWNER_DMEM;
                        req_d.we    = dmem_we;
                        req_d.addr  = 32'(dmem_addr);
                        req_d.wdata = 32'(dmem_wdata);
                        // Count only grants that actually made fetch wait.
                        if (!imem_req) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q != STARVE_LIMIT) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ARB_ISSUE: begin
                if (bus_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // Write completions leave the load-data register untouched.
                if (bus_rvalid) begin
                    state_d = ARB_RESP;
                    if (owner_q == OWNER_IMEM) begin
                        imem_rdata_d = bus_rdata;
                    end else if (!req_q.we) begin
                        dmem_rdata_d = bus_rdata;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_IMEM;
            req_q        <= '0;
            starve_cnt_q <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            starve_cnt_q <= starve_cnt_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    // Bus fields come straight from the capture register, so they stay
    // stable for as long as the bus stalls the request.
    assign bus_req    = (state_q == ARB_ISSUE);
    assign bus_we     = bus_req & req_q.we;
    assign bus_addr   = req_q.addr[AW-1:0];
    assign bus_wdata  = req_q.wdata[DW-1:0];
    assign imem_ack   = (state_q == ARB_RESP) && (owner_q == OWNER_IMEM);
    assign dmem_ack   = (state_q == ARB_RESP) && (owner_q == OWNER_DMEM);
    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;
    assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Requester drivers issue
// transactions, a bus slave answers with random stalls and spurious
// responses, and a negedge monitor predicts each grant from the arbitration
// rules, queues the expected bus transaction and ack, and compares them when
// the DUT presents them.
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready;
    logic          bus_rvalid;
    logic [DW-1:0] bus_rdata;
    logic          busy;

    mem_port_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busTxn_t;

    typedef struct {
        bit          isDmem;
        bit          isRead;
        logic [31:0] data;
    } ackTxn_t;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int lastLatency = 0;

    busTxn_t     busQ[$];
    ackTxn_t     ackQ[$];
    bit          ackOrder[$];
    logic [31:0] modelMem[logic [31:0]];
    logic [31:0] slaveMem[logic [31:0]];
    bit          modelIdle   = 1'b1;
    int          starveModel = 0;
    logic [31:0] heldImem    = '0;
    logic [31:0] heldDmem    = '0;

    bit          realRvalid    = 1'b0;
    bit          rvLatched     = 1'b0;
    bit          slvPending    = 1'b0;
    bit          slvOrphan     = 1'b0;
    int          slvDelay      = 0;
    logic [31:0] slvData       = '0;
    int          readyPct      = 100;
    int          rvMax         = 0;
    int          spurPct       = 0;
    int          readyDelay    = 0;
    int          forcedRvDelay = -1;

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Background memory contents seen by both the slave and the model.
    function automatic logic [31:0] initWord(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    function automatic logic [63:0] orderCode();
        logic [63:0] c = '0;
        foreach (ackOrder[i]) c = {c[62:0], ackOrder[i]};
        return c | (64'(ackOrder.size()) << 16);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=event-absent-or-extra required=protocol-conformant", name);
    endtask

    // Issue n transactions from one requester, holding each request until its
    // ack and changing it only in the cycle after the ack.
    task automatic applyStimulus(input bit isDmem, input int n, input int maxGap, input bit rnd,
                                 input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int gap;
        int t;
        int reqCycle;
        bit ackSeen;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(0, maxGap));
            if (gap > 0) begin
                if (isDmem) dmem_req = 1'b0; else imem_req = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (isDmem) begin
                dmem_req   = 1'b1;
                dmem_we    = rnd ? 1'($urandom_range(0, 1)) : we;
                dmem_addr  = rnd ? 32'h100 + 32'(4 * $urandom_range(0, 15)) : addr;
                dmem_wdata = rnd ? $urandom : wdata;
            end else begin
                imem_req  = 1'b1;
                imem_addr = rnd ? 32'h100 + 32'(4 * $urandom_range(0, 15)) : addr;
            end
            reqCycle = cycle;
            t = 0;
            ackSeen = 1'b0;
            while (!ackSeen && t < 300) begin
                @(negedge clk);
                t++;
                ackSeen = isDmem ? dmem_ack : imem_ack;
            end
            if (!ackSeen) begin
                failNow(isDmem ? "dmem_ack_timeout" : "imem_ack_timeout");
                if (isDmem) dmem_req = 1'b0; else imem_req = 1'b0;
                return;
            end
            lastLatency = cycle - reqCycle;
            @(posedge clk);
            #1;
        end
        if (isDmem) dmem_req = 1'b0; else imem_req = 1'b0;
    endtask

    // Bus slave: random accept stalls, response delay, spurious rvalid pulses
    // whenever no real response is owed.
    initial begin
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            realRvalid = 1'b0;
            bus_rvalid = 1'b0;
            if (slvPending) begin
                if (slvDelay == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = slvData;
                    slvPending = 1'b0;
                    realRvalid = !slvOrphan;
                    slvOrphan  = 1'b0;
                end else begin
                    slvDelay--;
                end
            end else if (int'($urandom_range(0, 99)) < spurPct) begin
                bus_rvalid = 1'b1;
                bus_rdata  = $urandom;
            end
            if (bus_req && readyDelay > 0) begin
                bus_ready = 1'b0;
                readyDelay--;
            end else begin
                bus_ready = int'($urandom_range(0, 99)) < readyPct;
            end
        end
    end

    // Monitor and scoreboard: predicts grants at idle cycles, checks bus
    // transactions on acceptance and acks when they appear.
    initial begin
        bit          expectAck;
        bit          nextIdle;
        bit          grantImem;
        bit          prevStall;
        logic [32:0] prevWeAddr;
        logic [31:0] prevWdata;
        logic [31:0] rd;
        busTxn_t     b;
        ackTxn_t     e;
        prevStall  = 1'b0;
        prevWeAddr = '0;
        prevWdata  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevStall = 1'b0;
                rvLatched = 1'b0;
            end else begin
                expectAck = rvLatched;
                rvLatched = realRvalid;
                nextIdle  = 1'b0;

                if (imem_ack || dmem_ack) begin
                    checkOutput("ack_exclusive", 64'(imem_ack & dmem_ack), 64'd0);
                    checkOutput("ack_after_rvalid", 64'(expectAck), 64'd1);
                    if (ackQ.size() == 0) begin
                        failNow("ack_unexpected");
                    end else begin
                        e = ackQ.pop_front();
                        checkOutput("ack_owner", 64'(dmem_ack), 64'(e.isDmem));
                        if (!e.isDmem) begin
                            heldImem = e.data;
                        end else if (e.isRead) begin
                            heldDmem = e.data;
                        end
                        checkOutput("imem_rdata", 64'(imem_rdata), 64'(heldImem));
                        checkOutput("dmem_rdata", 64'(dmem_rdata), 64'(heldDmem));
                    end
                    ackOrder.push_back(dmem_ack);
                    nextIdle = 1'b1;
                end else if (expectAck) begin
                    failNow("ack_missing");
                end

                if (bus_req) begin
                    if (prevStall) begin
                        checkOutput("stall_we_addr", 64'({bus_we, bus_addr}), 64'(prevWeAddr));
                        checkOutput("stall_wdata", 64'(bus_wdata), 64'(prevWdata));
                    end
                    if (bus_ready) begin
                        prevStall = 1'b0;
                        if (busQ.size() == 0) begin
                            failNow("bus_unexpected");
                        end else begin
                            b = busQ.pop_front();
                            checkOutput("bus_we", 64'(bus_we), 64'(b.we));
                            checkOutput("bus_addr", 64'(bus_addr), 64'(b.addr));
                            if (b.we) checkOutput("bus_wdata", 64'(bus_wdata), 64'(b.wdata));
                        end
                        slvPending = 1'b1;
                        slvDelay   = (forcedRvDelay >= 0) ? forcedRvDelay : int'($urandom_range(0, rvMax));
                        if (bus_we) begin
                            slaveMem[bus_addr] = bus_wdata;
                            slvData = $urandom;
                        end else begin
                            slvData = slaveMem.exists(bus_addr) ? slaveMem[bus_addr] : initWord(bus_addr);
                        end
                    end else begin
                        prevStall  = 1'b1;
                        prevWeAddr = {bus_we, bus_addr};
                        prevWdata  = bus_wdata;
                    end
                end else begin
                    prevStall = 1'b0;
                end

                if (modelIdle) begin
                    checkOutput("idle_busy", 64'(busy), 64'd0);
                    if (imem_req || dmem_req) begin
                        grantImem = imem_req && (!dmem_req || starveModel == STARVE_MAX);
                        if (grantImem) begin
                            starveModel = 0;
                            rd = modelMem.exists(imem_addr) ? modelMem[imem_addr] : initWord(imem_addr);
                            busQ.push_back('{we: 1'b0, addr: imem_addr, wdata: '0});
                            ackQ.push_back('{isDmem: 1'b0, isRead: 1'b1, data: rd});
                        end else begin
                            starveModel = imem_req ? ((starveModel < STARVE_MAX) ? starveModel + 1 : STARVE_MAX) : 0;
                            busQ.push_back('{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata});
                            if (dmem_we) begin
                                modelMem[dmem_addr] = dmem_wdata;
                                ackQ.push_back('{isDmem: 1'b1, isRead: 1'b0, data: '0});
                            end else begin
                                rd = modelMem.exists(dmem_addr) ? modelMem[dmem_addr] : initWord(dmem_addr);
                                ackQ.push_back('{isDmem: 1'b1, isRead: 1'b1, data: rd});
                            end
                        end
                        modelIdle = 1'b0;
                    end
                end
                if (nextIdle) modelIdle = 1'b1;
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #1_000_000;
        failNow("watchdog");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [31:0] heldBefore;
        reset      = 1'b1;
        imem_req   = 1'b0;
        imem_addr  = '0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_bus_req", 64'(bus_req), 64'd0);
        checkOutput("rst_bus_we", 64'(bus_we), 64'd0);
        checkOutput("rst_bus_addr", 64'(bus_addr), 64'd0);
        checkOutput("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        checkOutput("rst_imem_ack", 64'(imem_ack), 64'd0);
        checkOutput("rst_dmem_ack", 64'(dmem_ack), 64'd0);
        checkOutput("rst_imem_rdata", 64'(imem_rdata), 64'd0);
        checkOutput("rst_dmem_rdata", 64'(dmem_rdata), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single best-case fetch.
        applyStimulus(1'b0, 1, 0, 1'b0, 1'b0, 32'h10, '0);
        checkOutput("t1_latency", 64'(lastLatency), 64'd3);
        checkOutput("t1_imem_rdata", 64'(imem_rdata), 64'h0050_0093);

        // Simultaneous requests with an empty starvation count: dmem first.
        ackOrder.delete();
        fork
            applyStimulus(1'b1, 1, 0, 1'b0, 1'b0, 32'h104, '0);
            applyStimulus(1'b0, 1, 0, 1'b0, 1'b0, 32'h108, '0);
        join
        checkOutput("t2_order", orderCode(), 64'h0002_0002);

        // Both held continuously: D,D,D,D,I,D,D,D,D,I.
        ackOrder.delete();
        fork
            applyStimulus(1'b1, 8, 0, 1'b1, 1'b0, '0, '0);
            applyStimulus(1'b0, 2, 0, 1'b1, 1'b0, '0, '0);
        join
        checkOutput("t3_order", orderCode(), 64'h000A_03DE);

        // Stalled dmem write.
        heldBefore = dmem_rdata;
        readyDelay = 3;
        applyStimulus(1'b1, 1, 0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        checkOutput("t4_latency", 64'(lastLatency), 64'd6);
        checkOutput("t4_rdata_held", 64'(dmem_rdata), 64'(heldBefore));

        // Reset while waiting for the bus response; stale rvalid arrives later.
        forcedRvDelay = 5;
        dmem_req  = 1'b1;
        dmem_we   = 1'b0;
        dmem_addr = 32'h104;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("t5_busy_wait", 64'(busy), 64'd1);
        checkOutput("t5_bus_req_wait", 64'(bus_req), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_busy_rst", 64'(busy), 64'd0);
        checkOutput("t5_bus_addr_rst", 64'(bus_addr), 64'd0);
        checkOutput("t5_imem_rdata_rst", 64'(imem_rdata), 64'd0);
        checkOutput("t5_dmem_ack_rst", 64'(dmem_ack), 64'd0);
        dmem_req = 1'b0;
        busQ.delete();
        ackQ.delete();
        modelIdle   = 1'b1;
        starveModel = 0;
        heldImem    = '0;
        heldDmem    = '0;
        slvOrphan   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        forcedRvDelay = -1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t5_busy_after", 64'(busy), 64'd0);
        checkOutput("t5_dmem_ack_after", 64'(dmem_ack), 64'd0);

        // Spurious rvalid while idle and while stalled in ISSUE.
        spurPct = 100;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t6_idle_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
        readyDelay = 2;
        applyStimulus(1'b1, 1, 0, 1'b0, 1'b0, 32'h108, '0);
        checkOutput("t6_latency", 64'(lastLatency), 64'd5);
        spurPct = 0;

        // Randomized traffic from both requesters.
        readyPct = 60;
        rvMax    = 3;
        spurPct  = 25;
        fork
            applyStimulus(1'b0, 30, 3, 1'b1, 1'b0, '0, '0);
            applyStimulus(1'b1, 30, 3, 1'b1, 1'b0, '0, '0);
        join
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sb_ack_drained", 64'(ackQ.size()), 64'd0);
        checkOutput("sb_bus_drained", 64'(busQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
